// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline. It holds the ALU, shifter and set-less-than
// logic, the optional iterative mul/div sequencer that owns HI/LO, and the EX/MEM register.
// Optional feature macro: EX_MULDIV_EN. When it is defined, the mul/div FSM and HI/LO are built.
// When it is undefined, mult/div/mfhi/mflo produce 0 and stall_EX is tied low.
module ex_stage #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] read_data1_ID_EX,
   input  logic [DW-1:0] read_data2_ID_EX,
   input  logic [DW-1:0] word_ID_EX,
   input  logic [5:0]    funct_ID_EX,
   input  logic [3:0]    ALUOp_ID_EX,
   input  logic          ALUSrc_ID_EX,
   input  logic          RegDst_ID_EX,
   input  logic          Mem_Read_ID_EX,
   input  logic          Mem_Write_ID_EX,
   input  logic          Mem_to_Reg_ID_EX,
   input  logic          Reg_Write_ID_EX,
   input  logic [4:0]    rs2_ID_EX,
   input  logic [4:0]    rd_ID_EX,
   output logic [DW-1:0] alu_result_EX_MEM,
   output logic [DW-1:0] write_data_EX_MEM,
   output logic [4:0]    write_reg_EX_MEM,
   output logic          Mem_Read_EX_MEM,
   output logic          Mem_Write_EX_MEM,
   output logic          Mem_to_Reg_EX_MEM,
   output logic          Reg_Write_EX_MEM,
   output logic          stall_EX
);

   logic [DW-1:0] op_a, op_b, alu_res, hi_rd, lo_rd;
   logic [4:0]    shamt, dest;

   assign op_a  = read_data1_ID_EX;
   assign op_b  = ALUSrc_ID_EX ? word_ID_EX : read_data2_ID_EX;
   assign shamt = word_ID_EX[10:6];
   assign dest  = RegDst_ID_EX ? rd_ID_EX : rs2_ID_EX;

   // ALU result selection by operation class and, for R-type, by funct
   always_comb begin
      alu_res = '0;
      case (ALUOp_ID_EX)
         4'b0000: alu_res = op_a + op_b;
         4'b0001: alu_res = op_a - op_b;
         4'b0010: alu_res = op_a & op_b;
         4'b0011: alu_res = op_a | op_b;
         4'b0100: alu_res = op_a ^ op_b;
         4'b0101: alu_res = ~(op_a | op_b);
         4'b0110: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b0111: alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
         4'b1011: alu_res = op_b << 16;
         4'b1111: begin
            case (funct_ID_EX)
               6'h00:         alu_res = read_data2_ID_EX << shamt;
               6'h02:         alu_res = read_data2_ID_EX >> shamt;
               6'h03:         alu_res = $signed(read_data2_ID_EX) >>> shamt;
               6'h20, 6'h21:  alu_res = op_a + op_b;
               6'h22, 6'h23:  alu_res = op_a - op_b;
               6'h24:         alu_res = op_a & op_b;
               6'h25:         alu_res = op_a | op_b;
               6'h26:         alu_res = op_a ^ op_b;
               6'h27:         alu_res = ~(op_a | op_b);
               6'h2A:         alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               6'h2B:         alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
               6'h10:         alu_res = hi_rd;
               6'h12:         alu_res = lo_rd;
               default:       alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

   md_state_e       state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [2*DW-1:0] acc_q, acc_d, acc_step, mul_res;
   logic [DW-1:0]   op_q, op_d, hi_q, hi_d, lo_q, lo_d, quo, rem;
   logic            is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
   logic            muldiv_dec, sgn, sa, sb;
   logic [DW-1:0]   ma, mb;
   logic [DW:0]     add_sum, div_diff;
   logic [2*DW:0]   div_sh;

   // funct 0x18..0x1B: bit0 clear = signed, bit1 set = divide
   assign muldiv_dec = (ALUOp_ID_EX == 4'b1111) && (funct_ID_EX[5:2] == 4'b0110);
   assign sgn        = ~funct_ID_EX[0];
   assign sa         = sgn & read_data1_ID_EX[DW-1];
   assign sb         = sgn & read_data2_ID_EX[DW-1];
   assign ma         = sa ? -read_data1_ID_EX : read_data1_ID_EX;
   assign mb         = sb ? -read_data2_ID_EX : read_data2_ID_EX;

   assign hi_rd      = hi_q;
   assign lo_rd      = lo_q;
   // Stall is forced low while reset is asserted so the hazard unit releases immediately
   assign stall_EX   = rst_n & (((state_q == StIdle) & muldiv_dec) | (state_q == StBusy));

   // One iteration: shift-add for multiply, restoring subtract for divide
   always_comb begin
      add_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, op_q} : '0);
      div_sh   = {acc_q, 1'b0};
      div_diff = div_sh[2*DW:DW] - {1'b0, op_q};
      if (is_div_q) begin
         if (!div_diff[DW]) acc_step = {div_diff[DW-1:0], div_sh[DW-1:1], 1'b1};
         else               acc_step = div_sh[2*DW-1:0];
      end else begin
         acc_step = {add_sum, acc_q[DW-1:1]};
      end
      mul_res = neg_q ? -acc_step : acc_step;
      quo     = neg_q ? -acc_step[DW-1:0] : acc_step[DW-1:0];
      rem     = rneg_q ? -acc_step[2*DW-1:DW] : acc_step[2*DW-1:DW];
   end

   // Sequencer next state: latch magnitudes, iterate, sign-correct into HI/LO
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      case (state_q)
         StIdle: begin
            if (muldiv_dec) begin
               is_div_d = funct_ID_EX[1];
               neg_d    = sa ^ sb;
               rneg_d   = sa;
               div0_d   = (read_data2_ID_EX == '0);
               op_d     = funct_ID_EX[1] ? mb : ma;
               acc_d    = {{DW{1'b0}}, (funct_ID_EX[1] ? ma : mb)};
               cnt_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DW-1)) begin
               if (is_div_q) begin
                  hi_d = rem;
                  lo_d = div0_q ? '1 : quo;
               end else begin
                  hi_d = mul_res[2*DW-1:DW];
                  lo_d = mul_res[DW-1:0];
               end
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Sequencer and HI/LO state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
      end
   end
`else
   assign hi_rd    = '0;
   assign lo_rd    = '0;
   assign stall_EX = 1'b0;
`endif

   // EX/MEM pipeline register; a stall inserts a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_EX_MEM <= '0;
         write_data_EX_MEM <= '0;
         write_reg_EX_MEM  <= '0;
         Mem_Read_EX_MEM   <= 1'b0;
         Mem_Write_EX_MEM  <= 1'b0;
         Mem_to_Reg_EX_MEM <= 1'b0;
         Reg_Write_EX_MEM  <= 1'b0;
      end else if (stall_EX) begin
         alu_result_EX_MEM <= '0;
         write_data_EX_MEM <= '0;
         write_reg_EX_MEM  <= '0;
         Mem_Read_EX_MEM   <= 1'b0;
         Mem_Write_EX_MEM  <= 1'b0;
         Mem_to_Reg_EX_MEM <= 1'b0;
         Reg_Write_EX_MEM  <= 1'b0;
      end else begin
         alu_result_EX_MEM <= alu_res;
         write_data_EX_MEM <= read_data2_ID_EX;
         write_reg_EX_MEM  <= dest;
         Mem_Read_EX_MEM   <= Mem_Read_ID_EX;
         Mem_Write_EX_MEM  <= Mem_Write_ID_EX;
         Mem_to_Reg_EX_MEM <= Mem_to_Reg_ID_EX;
         Reg_Write_EX_MEM  <= Reg_Write_ID_EX;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random and directed stimulus for ex_stage, checked every cycle against an
// instruction-level model (plain arithmetic for results, whole-instruction latency for mul/div).
module tb_ex_stage;

`ifdef EX_MULDIV_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] a, b, imm;
      logic [5:0]  funct;
      logic [3:0]  aluop;
      logic        alusrc, regdst, mr, mw, m2r, rw;
      logic [4:0]  rs2, rd;
   } instr_t;

   typedef struct packed {
      logic [31:0] alu, wd;
      logic [4:0]  wr;
      logic        mr, mw, m2r, rw;
   } out_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rd1, rd2, word;
   logic [5:0]  funct;
   logic [3:0]  aluop;
   logic        alusrc, regdst, mr_i, mw_i, m2r_i, rw_i;
   logic [4:0]  rs2, rd;
   logic [31:0] alu_o, wd_o;
   logic [4:0]  wr_o;
   logic        mr_o, mw_o, m2r_o, rw_o, stall;

   int          n_tests = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   bit          exp_stall = 1'b0;
   out_t        exp_out = '0;
   logic [31:0] m_hi = '0, m_lo = '0;

   ex_stage #(.DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_data1_ID_EX(rd1), .read_data2_ID_EX(rd2), .word_ID_EX(word),
      .funct_ID_EX(funct), .ALUOp_ID_EX(aluop), .ALUSrc_ID_EX(alusrc), .RegDst_ID_EX(regdst),
      .Mem_Read_ID_EX(mr_i), .Mem_Write_ID_EX(mw_i), .Mem_to_Reg_ID_EX(m2r_i),
      .Reg_Write_ID_EX(rw_i), .rs2_ID_EX(rs2), .rd_ID_EX(rd),
      .alu_result_EX_MEM(alu_o), .write_data_EX_MEM(wd_o), .write_reg_EX_MEM(wr_o),
      .Mem_Read_EX_MEM(mr_o), .Mem_Write_EX_MEM(mw_o), .Mem_to_Reg_EX_MEM(m2r_o),
      .Reg_Write_EX_MEM(rw_o), .stall_EX(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] exp_md(input logic [31:0] v);
      return EN ? v : 32'd0;
   endfunction

   function automatic instr_t mk(input logic [3:0] op, input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm, input logic src,
                                 input logic [4:0] dst, input logic [3:0] ctrl);
      instr_t t;
      t.a = a; t.b = b; t.imm = imm; t.funct = f; t.aluop = op; t.alusrc = src;
      t.regdst = 1'b1; t.rd = dst; t.rs2 = 5'd31 - dst;
      {t.mr, t.mw, t.m2r, t.rw} = ctrl;
      return t;
   endfunction

   function automatic bit is_md(input instr_t t);
      return (t.aluop == 4'hF) && (t.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
   endfunction

   // {HI, LO} of a mult/div, straight from the arithmetic definitions
   function automatic logic [63:0] model_muldiv(input logic [5:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
      longint pa, pb;
      int     qa, qb, q, r;
      logic [63:0] ua, ub;
      pa = $signed(a); pb = $signed(b);
      ua = {32'd0, a}; ub = {32'd0, b};
      case (f)
         6'h18: return 64'(pa * pb);
         6'h19: return ua * ub;
         6'h1A: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            qa = $signed(a); qb = $signed(b);
            q = qa / qb; r = qa % qb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] model_alu(input instr_t t);
      logic [31:0] a, b;
      int sh;
      a = t.a;
      b = t.alusrc ? t.imm : t.b;
      sh = int'(t.imm[10:6]);
      case (t.aluop)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return ~(a | b);
         4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h7: return (a < b) ? 32'd1 : 32'd0;
         4'hB: return b << 16;
         4'hF: begin
            case (t.funct)
               6'h00: return t.b << sh;
               6'h02: return t.b >> sh;
               6'h03: return $signed(t.b) >>> sh;
               6'h20, 6'h21: return a + b;
               6'h22, 6'h23: return a - b;
               6'h24: return a & b;
               6'h25: return a | b;
               6'h26: return a ^ b;
               6'h27: return ~(a | b);
               6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: return (a < b) ? 32'd1 : 32'd0;
               6'h10: return EN ? m_hi : 32'd0;
               6'h12: return EN ? m_lo : 32'd0;
               default: return 32'd0;
            endcase
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input instr_t t);
      rd1 = t.a; rd2 = t.b; word = t.imm; funct = t.funct; aluop = t.aluop;
      alusrc = t.alusrc; regdst = t.regdst; mr_i = t.mr; mw_i = t.mw; m2r_i = t.m2r;
      rw_i = t.rw; rs2 = t.rs2; rd = t.rd;
   endtask

   // Presents one instruction, held while the model says EX is occupied; starts at posedge+1
   task automatic run_instr(input instr_t t);
      int   n;
      out_t o;
      n = (EN && is_md(t)) ? 33 : 0;
      o.alu = model_alu(t);
      o.wd  = t.b;
      o.wr  = t.regdst ? t.rd : t.rs2;
      o.mr  = t.mr; o.mw = t.mw; o.m2r = t.m2r; o.rw = t.rw;
      for (int c = 0; c <= n; c++) begin
         drive(t);
         exp_stall = (c < n);
         @(posedge clk);
         #1;
         exp_out = (c < n) ? '0 : o;
         chk_en  = 1'b1;
      end
      if (n != 0) {m_hi, m_lo} = model_muldiv(t.funct, t.a, t.b);
   endtask

   // Per-cycle comparison of the combinational stall and the registered EX/MEM outputs
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall_EX", {63'd0, stall}, {63'd0, exp_stall});
         check("alu_result", {32'd0, alu_o}, {32'd0, exp_out.alu});
         check("write_data", {32'd0, wd_o}, {32'd0, exp_out.wd});
         check("write_reg", {59'd0, wr_o}, {59'd0, exp_out.wr});
         check("ctrl", {60'd0, mr_o, mw_o, m2r_o, rw_o},
               {60'd0, exp_out.mr, exp_out.mw, exp_out.m2r, exp_out.rw});
      end
   end

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($signed($urandom_range(0, 40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   function automatic instr_t rand_instr();
      logic [5:0] fl [20] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A,
                              6'h1B, 6'h3F};
      logic [3:0] oth [6] = '{4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
      instr_t t;
      int k;
      t = mk(4'h0, 6'h0, rand_word(), rand_word(), rand_word(), 1'($urandom),
             5'($urandom), 4'($urandom));
      t.regdst = 1'($urandom);
      t.rs2 = 5'($urandom);
      t.funct = fl[$urandom_range(0, 19)];
      k = $urandom_range(0, 19);
      if (k < 8)       t.aluop = 4'(k);
      else if (k == 8) t.aluop = 4'hB;
      else if (k == 9) t.aluop = oth[$urandom_range(0, 5)];
      else begin
         t.aluop = 4'hF;
         t.alusrc = 1'b0;
      end
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      // Model pins: hand-computed values
      check("pin_add", {32'd0, model_alu(mk(4'hF, 6'h20, 5, 7, 0, 0, 3, 4'b0001))}, 64'd12);
      check("pin_lw", {32'd0, model_alu(mk(4'h0, 6'h0, 32'h1000, 0, 32'hFFFF_FFFC, 1, 3,
            4'b1011))}, 64'h0000_0FFC);
      check("pin_sra", {32'd0, model_alu(mk(4'hF, 6'h03, 0, 32'h8000_0000, 32'h100, 0, 3,
            4'b0001))}, 64'hF800_0000);
      check("pin_mult", model_muldiv(6'h18, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
      check("pin_divu0", model_muldiv(6'h1B, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
      check("pin_div", model_muldiv(6'h1A, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

      // Reset state, with a mult presented so stall gating by reset is exercised
      drive(mk(4'hF, 6'h18, 32'h55, 32'h66, 32'h77, 0, 5'd9, 4'b1111));
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_alu", {32'd0, alu_o}, 64'd0);
      check("rst_ctrl", {55'd0, wr_o, mr_o, mw_o, m2r_o, rw_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b0;
      m_hi = '0; m_lo = '0;

      // Directed cases
      run_instr(mk(4'hF, 6'h20, 32'd5, 32'd7, 32'd0, 0, 5'd3, 4'b0001));
      check("add_lit", {32'd0, alu_o}, 64'd12);
      check("add_wr", {59'd0, wr_o}, 64'd3);
      run_instr(mk(4'h0, 6'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 1, 5'd4, 4'b1011));
      check("lw_lit", {32'd0, alu_o}, 64'h0FFC);
      check("lw_ctrl", {62'd0, mr_o, m2r_o}, 64'd3);
      run_instr(mk(4'hF, 6'h03, 32'h0, 32'h8000_0000, 32'd4 << 6, 0, 5'd5, 4'b0001));
      check("sra_lit", {32'd0, alu_o}, 64'hF800_0000);
      run_instr(mk(4'h7, 6'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 5'd6, 4'b0001));
      check("sltu_lit", {32'd0, alu_o}, 64'd1);

      run_instr(mk(4'hF, 6'h18, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h12, 0, 0, 0, 0, 5'd7, 4'b0001));
      check("mflo_mult", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFA)});
      run_instr(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      check("mfhi_mult", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFF)});

      run_instr(mk(4'hF, 6'h1B, 32'd100, 32'd0, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h12, 0, 0, 0, 0, 5'd7, 4'b0001));
      check("mflo_div0", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFF)});
      run_instr(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      check("mfhi_div0", {32'd0, alu_o}, {32'd0, exp_md(32'd100)});

      run_instr(mk(4'hF, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h12, 0, 0, 0, 0, 5'd7, 4'b0001));
      check("mflo_sdiv", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFD)});
      run_instr(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      check("mfhi_sdiv", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFF)});

      run_instr(mk(4'hF, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h12, 0, 0, 0, 0, 5'd7, 4'b0001));
      check("mflo_ovf", {32'd0, alu_o}, {32'd0, exp_md(32'h8000_0000)});
      run_instr(mk(4'hF, 6'h1A, 32'hFFFF_FFF0, 32'd0, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 5'd0, 4'b0000));
      run_instr(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      check("mfhi_b2b", {32'd0, alu_o}, {32'd0, exp_md(32'hFFFF_FFFE)});

      // Reset in the middle of a mult: outputs and stall drop at once, HI/LO cleared
      chk_en = 1'b0;
      drive(mk(4'hF, 6'h18, 32'd1234, 32'd5678, 32'd0, 0, 5'd9, 4'b0001));
      repeat (11) @(posedge clk);
      #1;
      check("busy_stall", {63'd0, stall}, {63'd0, EN});
      rst_n = 1'b0;
      #1;
      check("midrst_stall", {63'd0, stall}, 64'd0);
      check("midrst_out", {23'd0, alu_o, wr_o, mr_o, mw_o, m2r_o, rw_o}, 64'd0);
      drive(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
      @(posedge clk);
      #1;
      run_instr(mk(4'hF, 6'h10, 0, 0, 0, 0, 5'd8, 4'b0001));
      check("mfhi_after_rst", {32'd0, alu_o}, 64'd0);
      run_instr(mk(4'hF, 6'h12, 0, 0, 0, 0, 5'd7, 4'b0001));
      check("mflo_after_rst", {32'd0, alu_o}, 64'd0);

      // Randomized traffic
      for (int i = 0; i < 250; i++) run_instr(rand_instr());
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
